icache_direct: RTL

Direct-mapped, read-only instruction cache that sits between one core's fetch stage and one instruction port of `memory_control`. It serves fetches from local frames and, on a miss, issues two back-to-back single-word reads on `iREN`/`iaddr` to fill a two-word block. Each core instantiates one copy, tied to index 0 or 1 of the controller's `iREN`/`iaddr`/`iwait`/`iload` vectors.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/icache_direct_sat_counter.sv | 35 +++
 rtl/icache_direct.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the basic machine word plus the instruction-cache frame layout.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Default cache geometry; the frame type below is sized for it.
    localparam int ICACHE_SETS = 8;

    // Tag width for a direct-mapped cache of two-word blocks:
    // word address bits minus the index bits minus the block-offset bit.
    function automatic int icache_tag_w(input int sets);
        return WORD_W - $clog2(sets) - 3;
    endfunction

    localparam int ICACHE_TAG_W = icache_tag_w(ICACHE_SETS);

    // One cache frame: valid flag, tag and the two words of the block.
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t [1:0]             word;
    } icache_frame_t;

endpackage

// File: rtl/icache_direct_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter
    import cpu_types_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Advance only when requested and not already at the ceiling.
    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with two-word blocks.
// Hits are answered combinationally from the frame arrays; a miss fills the
// block with two back-to-back single-word reads on iREN/iaddr.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = icache_tag_w(SETS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } icache_state_t;

    icache_state_t state_reg, state_next;
    logic [TAG_W-1:0] miss_tag_reg, miss_tag_next;
    logic [IDX_W-1:0] miss_idx_reg, miss_idx_next;
    word_t            buf0_reg, buf0_next;
    logic             flush_pend_reg, flush_pend_next;
    logic [SETS-1:0]  valid_reg, valid_next;
    logic             frame_we;

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    logic [TAG_W-1:0] tag_mem   [SETS];
    word_t            word0_mem [SETS];
    word_t            word1_mem [SETS];

    // Fetch address split: tag | index | block offset | byte.
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_off;
    logic             lookup_hit;
    logic             miss_start;
    logic [1:0]       unused_byte;

    assign req_tag     = imemaddr[31 -: TAG_W];
    assign req_idx     = imemaddr[IDX_W+2:3];
    assign req_off     = imemaddr[2];
    assign unused_byte = imemaddr[1:0];

    assign lookup_hit = imemREN && valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

    // Hits are only reported while idle; during a fill the arrays are busy.
    assign ihit       = (state_reg == IDLE) && lookup_hit;
    assign imemload   = ihit ? (req_off ? word1_mem[req_idx] : word0_mem[req_idx]) : '0;
    assign miss_start = (state_reg == IDLE) && imemREN && !lookup_hit;

    // Next-state, bus request and valid-bit bookkeeping for the fill sequence.
    always_comb begin
        state_next      = state_reg;
        miss_tag_next   = miss_tag_reg;
        miss_idx_next   = miss_idx_reg;
        buf0_next       = buf0_reg;
        flush_pend_next = flush_pend_reg;
        valid_next      = valid_reg;
        frame_we        = 1'b0;
        iREN            = 1'b0;
        iaddr           = '0;

        case (state_reg)
            IDLE: begin
                // The lookup above still sees the pre-flush valid bits.
                if (iflush) begin
                    valid_next = '0;
                end
                if (miss_start) begin
                    miss_tag_next = req_tag;
                    miss_idx_next = req_idx;
                    state_next    = FETCH0;
                end
            end

            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_reg, miss_idx_reg, 3'b000};
                if (iflush) begin
                    flush_pend_next = 1'b1;
                end
                if (!iwait) begin
                    buf0_next  = iload;
                    state_next = FETCH1;
                end
            end

            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_reg, miss_idx_reg, 3'b100};
                if (iflush) begin
                    flush_pend_next = 1'b1;
                end
                if (!iwait) begin
                    state_next = IDLE;
                    // A flush seen at any point of the fill discards the block
                    // and wipes every frame as the fill finishes.
                    if (flush_pend_reg || iflush) begin
                        valid_next      = '0;
                        flush_pend_next = 1'b0;
                    end else begin
                        valid_next[miss_idx_reg] = 1'b1;
                        frame_we                 = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state; reset abandons any fill in progress.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            miss_tag_reg   <= '0;
            miss_idx_reg   <= '0;
            buf0_reg       <= '0;
            flush_pend_reg <= 1'b0;
            valid_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            miss_tag_reg   <= miss_tag_next;
            miss_idx_reg   <= miss_idx_next;
            buf0_reg       <= buf0_next;
            flush_pend_reg <= flush_pend_next;
            valid_reg      <= valid_next;
        end
    end

    // Frame write at the edge that completes the second word of the fill.
    always_ff @(posedge CLK) begin
        if (frame_we) begin
            tag_mem[miss_idx_reg]   <= miss_tag_reg;
            word0_mem[miss_idx_reg] <= buf0_reg;
            word1_mem[miss_idx_reg] <= iload;
        end
    end

    sat_counter #(.W(32)) u_hit_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (ihit),
        .count (hit_count)
    );

    sat_counter #(.W(32)) u_miss_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (miss_start),
        .count (miss_count)
    );

endmodule
